// File: rtl/audio_stream_ctrl_if.sv
// Handshake and data bundle between the audio sequencer,
// the CODEC FIFOs and the stereo filter datapath.
interface audio_stream_ctrl_if #(
  parameter int DATA_W = 24
);
  logic              enable;
  logic              read_ready;
  logic [DATA_W-1:0] readdata_left;
  logic [DATA_W-1:0] readdata_right;
  logic              write_ready;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;
  logic              filt_start;
  logic [DATA_W-1:0] filt_in_left;
  logic [DATA_W-1:0] filt_in_right;
  logic              filt_done;
  logic [DATA_W-1:0] filt_out_left;
  logic [DATA_W-1:0] filt_out_right;
  logic              busy;
  logic [15:0]       timeout_cnt;

  modport master (
    input  enable, read_ready,
    input  readdata_left, readdata_right,
    input  write_ready, filt_done,
    input  filt_out_left, filt_out_right,
    output read, write,
    output writedata_left, writedata_right,
    output filt_start,
    output filt_in_left, filt_in_right,
    output busy, timeout_cnt
  );

  modport slave (
    output enable, read_ready,
    output readdata_left, readdata_right,
    output write_ready, filt_done,
    output filt_out_left, filt_out_right,
    input  read, write,
    input  writedata_left, writedata_right,
    input  filt_start,
    input  filt_in_left, filt_in_right,
    input  busy, timeout_cnt
  );
endinterface

// File: rtl/audio_stream_ctrl.sv
// Sequencer: CODEC pop -> filter -> CODEC push, one sample in flight.
// AUDIO_CTRL_BYPASS_EN adds a bypass input that skips the filter.
module audio_stream_ctrl #(
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
`ifdef AUDIO_CTRL_BYPASS_EN
  input  logic bypass,
`endif
  audio_stream_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_FILT,
    WAIT_WR,
    WRITE
  } state_e;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              start_q, start_d;
  logic              busy_q;
  logic [DATA_W-1:0] fil_q, fil_d;
  logic [DATA_W-1:0] fir_q, fir_d;
  logic [DATA_W-1:0] wdl_q, wdl_d;
  logic [DATA_W-1:0] wdr_q, wdr_d;
  logic [7:0]        wd_q, wd_d;
  logic [15:0]       tcnt_q, tcnt_d;

  // Next state, strobes and datapath captures.
  always_comb begin
    state_d = state_q;
    read_d  = 1'b0;
    write_d = 1'b0;
    start_d = 1'b0;
    fil_d   = fil_q;
    fir_d   = fir_q;
    wdl_d   = wdl_q;
    wdr_d   = wdr_q;
    wd_d    = wd_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && bus.read_ready) begin
          fil_d   = bus.readdata_left;
          fir_d   = bus.readdata_right;
          read_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        wd_d = '0;
`ifdef AUDIO_CTRL_BYPASS_EN
        if (bypass) begin
          wdl_d   = fil_q;
          wdr_d   = fir_q;
          state_d = WAIT_WR;
        end else begin
          start_d = 1'b1;
          state_d = WAIT_FILT;
        end
`else
        start_d = 1'b1;
        state_d = WAIT_FILT;
`endif
      end
      WAIT_FILT: begin
        wd_d = wd_q + 8'd1;
        if (bus.filt_done) begin
          wdl_d   = bus.filt_out_left;
          wdr_d   = bus.filt_out_right;
          state_d = WAIT_WR;
        end else if (wd_q == WD_LAST) begin
          wdl_d   = fil_q;
          wdr_d   = fir_q;
          if (tcnt_q != 16'hFFFF) begin
            tcnt_d = tcnt_q + 16'd1;
          end
          state_d = WAIT_WR;
        end
      end
      WAIT_WR: begin
        if (bus.write_ready) begin
          write_d = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      fil_q   <= '0;
      fir_q   <= '0;
      wdl_q   <= '0;
      wdr_q   <= '0;
      wd_q    <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      write_q <= write_d;
      start_q <= start_d;
      busy_q  <= (state_d != IDLE);
      fil_q   <= fil_d;
      fir_q   <= fir_d;
      wdl_q   <= wdl_d;
      wdr_q   <= wdr_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign bus.read            = read_q;
  assign bus.write           = write_q;
  assign bus.filt_start      = start_q;
  assign bus.busy            = busy_q;
  assign bus.filt_in_left    = fil_q;
  assign bus.filt_in_right   = fir_q;
  assign bus.writedata_left  = wdl_q;
  assign bus.writedata_right = wdr_q;
  assign bus.timeout_cnt     = tcnt_q;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed + random bench for audio_stream_ctrl.
// Expected timing/data come from a cycle-count formula per sample.
module tb_audio_stream_ctrl;
  localparam int DW    = 24;
  localparam int TO    = 64;
  localparam int NEVER = 100000;

  logic clk = 1'b0;
  logic reset;
`ifdef AUDIO_CTRL_BYPASS_EN
  logic bypass;
`endif
  always #5 clk = ~clk;

  audio_stream_ctrl_if #(.DATA_W(DW)) bus ();

  audio_stream_ctrl #(
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
`ifdef AUDIO_CTRL_BYPASS_EN
    .bypass(bypass),
`endif
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int exp_tcnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".read"}, 32'(bus.read), 0);
    chk({tag, ".write"}, 32'(bus.write), 0);
    chk({tag, ".start"}, 32'(bus.filt_start), 0);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk({tag, ".wdl"}, 32'(bus.writedata_left), 0);
    chk({tag, ".wdr"}, 32'(bus.writedata_right), 0);
    chk({tag, ".fil"}, 32'(bus.filt_in_left), 0);
    chk({tag, ".fir"}, 32'(bus.filt_in_right), 0);
    chk({tag, ".tcnt"}, 32'(bus.timeout_cnt), 0);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One sample: d = filter delay after filt_start, w = cycle
  // at which write_ready is raised. Read lands at cycle 1.
  task automatic run_sample(input string tag,
                            input logic [DW-1:0] l,
                            input logic [DW-1:0] r,
                            input logic [DW-1:0] fl,
                            input logic [DW-1:0] fr,
                            input int d,
                            input int w,
                            input bit byp);
    int cyc = 0;
    int rd_n = 0, st_n = 0, wr_n = 0;
    int rd_c = -1, st_c = -1, wr_c = -1;
    int ovl = 0, idle_n = 0, done_at = -1;
    int exp_wc;
    bit fb;
    logic [DW-1:0] gl, gr, el, er;
    gl = '0;
    gr = '0;
    fb = !byp && (d > TO - 1);
    if (byp) exp_wc = imax(2, w) + 1;
    else exp_wc = imax(3 + imin(d, TO - 1), w) + 1;
    el = (byp || fb) ? l : fl;
    er = (byp || fb) ? r : fr;
    if (fb && exp_tcnt < 16'hFFFF) exp_tcnt++;
    @(negedge clk);
    bus.readdata_left  = l;
    bus.readdata_right = r;
    bus.enable         = 1'b1;
    bus.read_ready     = 1'b1;
    bus.write_ready    = (w == 0);
    bus.filt_done      = 1'b0;
    bus.filt_out_left  = ~fl;
    bus.filt_out_right = ~fr;
`ifdef AUDIO_CTRL_BYPASS_EN
    bypass = byp;
`endif
    while (cyc < 400 && (wr_c < 0 || cyc < wr_c + 3)) begin
      @(negedge clk);
      cyc++;
      if (bus.read) begin
        rd_n++;
        if (rd_c < 0) rd_c = cyc;
      end
      if (bus.filt_start) begin
        st_n++;
        if (st_c < 0) st_c = cyc;
        done_at = (d >= NEVER) ? -1 : cyc + d;
      end
      if (bus.write) begin
        wr_n++;
        if (wr_c < 0) begin
          wr_c = cyc;
          gl = bus.writedata_left;
          gr = bus.writedata_right;
        end
      end
      if (bus.read && bus.write) ovl++;
      if (rd_c > 0 && wr_c < 0 && !bus.busy) idle_n++;
      bus.filt_done      = (cyc == done_at);
      bus.filt_out_left  = (cyc == done_at) ? fl : ~fl;
      bus.filt_out_right = (cyc == done_at) ? fr : ~fr;
      bus.write_ready    = (cyc >= w);
      if (wr_c > 0) bus.enable = 1'b0;
    end
    bus.enable    = 1'b0;
    bus.filt_done = 1'b0;
    chk({tag, ".rd_cyc"}, rd_c, 1);
    chk({tag, ".rd_n"}, rd_n, 1);
    chk({tag, ".st_n"}, st_n, byp ? 0 : 1);
    chk({tag, ".st_cyc"}, st_c, byp ? -1 : 2);
    chk({tag, ".wr_cyc"}, wr_c, exp_wc);
    chk({tag, ".wr_n"}, wr_n, 1);
    chk({tag, ".wdl"}, 32'(gl), 32'(el));
    chk({tag, ".wdr"}, 32'(gr), 32'(er));
    chk({tag, ".overlap"}, ovl, 0);
    chk({tag, ".busy"}, idle_n, 0);
    chk({tag, ".tcnt"}, 32'(bus.timeout_cnt), exp_tcnt);
  endtask

  initial begin
    int wr_n;
    int d, w;
    bit byp;
    reset              = 1'b1;
    bus.enable         = 1'($urandom);
    bus.read_ready     = 1'($urandom);
    bus.write_ready    = 1'($urandom);
    bus.filt_done      = 1'($urandom);
    bus.readdata_left  = DW'($urandom);
    bus.readdata_right = DW'($urandom);
    bus.filt_out_left  = DW'($urandom);
    bus.filt_out_right = DW'($urandom);
`ifdef AUDIO_CTRL_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (4) begin
      @(negedge clk);
      bus.enable    = 1'($urandom);
      bus.filt_done = 1'($urandom);
    end
    chk_zero("reset");
    bus.enable    = 1'b0;
    bus.filt_done = 1'b0;
    reset         = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("post_reset");

    run_sample("basic", 24'h000100, 24'hFFFF00,
               24'h000020, 24'hFFFFE0, 1, 0, 1'b0);
    run_sample("timeout", 24'h000100, 24'hFFFF00,
               24'h000020, 24'hFFFFE0, NEVER, 0, 1'b0);
    run_sample("wr_stall", 24'h123456, 24'h654321,
               24'h0A0B0C, 24'hF0E0D0, 1, 24, 1'b0);

    // Abort a sample parked in WAIT_WR with an async reset.
    @(negedge clk);
    bus.readdata_left  = 24'h0000AA;
    bus.readdata_right = 24'h0000BB;
    bus.enable         = 1'b1;
    bus.read_ready     = 1'b1;
    bus.write_ready    = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.filt_done = (c == 3);
      if (c == 2) bus.enable = 1'b0;
    end
    chk("abort.busy_before", 32'(bus.busy), 1);
    #2 reset = 1'b1;
    #1 chk_zero("abort");
    exp_tcnt = 0;
    @(negedge clk);
    reset           = 1'b0;
    bus.write_ready = 1'b1;
    wr_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.write) wr_n++;
    end
    chk("abort.no_write", wr_n, 0);
    run_sample("after_abort", 24'h000100, 24'hFFFF00,
               24'h000020, 24'hFFFFE0, 1, 0, 1'b0);

    run_sample("coincide", 24'h111111, 24'h222222,
               24'h333333, 24'h444444, TO - 1, 0, 1'b0);
    run_sample("late_done", 24'h555555, 24'h666666,
               24'h777777, 24'h888888, TO, 0, 1'b0);
`ifdef AUDIO_CTRL_BYPASS_EN
    run_sample("bypass", 24'h7FFFFF, 24'h800000,
               24'h000001, 24'h000002, 1, 0, 1'b1);
`endif

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0:       d = NEVER;
        1:       d = TO - 1;
        2:       d = TO;
        default: d = $urandom_range(1, 10);
      endcase
      w = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 12);
      byp = 1'b0;
`ifdef AUDIO_CTRL_BYPASS_EN
      byp = 1'($urandom);
`endif
      run_sample($sformatf("rnd%0d", i),
                 DW'($urandom), DW'($urandom),
                 DW'($urandom), DW'($urandom), d, w, byp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
